// File: rtl/alu_shft_pkg.sv
// Shared shift/rotate op encodings and helpers for distributing barrel levels over pipeline stages.
package alu_shft_pkg;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b011,
    OP_ROL = 3'b100,
    OP_ROR = 3'b101
  } shft_op_e;

  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // The first (s mod stg) stages each take one extra level.
  function automatic int unsigned lvl_cnt(input int unsigned k, input int unsigned s,
                                          input int unsigned stg);
    return (s / stg) + ((k < (s % stg)) ? 32'd1 : 32'd0);
  endfunction

  function automatic int unsigned lvl_lo(input int unsigned k, input int unsigned s,
                                         input int unsigned stg);
    return (k * (s / stg)) + ((k < (s % stg)) ? k : (s % stg));
  endfunction

endpackage

// File: rtl/alu_shft_stage.sv
// One pipeline stage: barrel levels LO..LO+CNT-1 feeding a valid/data register.
module alu_shft_stage
  import alu_shft_pkg::*;
#(
  parameter int unsigned N   = 32,
  parameter int unsigned S   = 5,
  parameter int unsigned LO  = 0,
  parameter int unsigned CNT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         adv,
  input  logic         in_v,
  input  logic [N-1:0] in_d,
  input  logic [2:0]   in_op,
  input  logic [S-1:0] in_sh,
  input  logic         in_err,
  output logic         out_v,
  output logic [N-1:0] out_d,
  output logic [2:0]   out_op,
  output logic [S-1:0] out_sh,
  output logic         out_err
);

  logic [N-1:0] d;

  // Illegal ops fall through every level untouched, so data arrives unchanged.
  always_comb begin
    d = in_d;
    for (int unsigned j = LO; j < LO + CNT; j++) begin
      if (in_sh[j]) begin
        case (in_op)
          OP_SLL:  d = d << (32'd1 << j);
          OP_SRL:  d = d >> (32'd1 << j);
          OP_SRA:  d = $signed(d) >>> (32'd1 << j);
          OP_ROL:  d = (d << (32'd1 << j)) | (d >> (N - (32'd1 << j)));
          OP_ROR:  d = (d >> (32'd1 << j)) | (d << (N - (32'd1 << j)));
          default: d = d;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v   <= 1'b0;
      out_d   <= '0;
      out_op  <= '0;
      out_sh  <= '0;
      out_err <= 1'b0;
    end else if (flush) begin
      out_v <= 1'b0;
    end else if (adv) begin
      out_v <= in_v;
      if (in_v) begin
        out_d   <= d;
        out_op  <= in_op;
        out_sh  <= in_sh;
        out_err <= in_err;
      end
    end
  end

endmodule

// File: rtl/alu_shft_pipe.sv
// Pipelined shift/rotate unit: STG register stages with valid/ready handshake and bubble collapsing.
module alu_shft_pipe
  import alu_shft_pkg::*;
#(
  parameter int unsigned N   = 32,
  parameter int unsigned S   = 5,
  parameter int unsigned STG = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [S-1:0] shamt,
  input  logic [2:0]   shft_op,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] shft_result,
  output logic         out_err
);

  logic         v   [STG];
  logic [N-1:0] d   [STG];
  logic [2:0]   op  [STG];
  logic [S-1:0] sh  [STG];
  logic         err [STG];
  logic         go  [STG];
  logic         acc;
  logic         s0_v;
  logic         s0_err;

  // A stage may load when it, or any stage downstream of it, has a free slot.
  always_comb begin
    acc = out_ready;
    for (int unsigned i = STG; i >= 1; i--) begin
      acc     = acc || !v[i-1];
      go[i-1] = acc;
    end
  end

  assign in_ready = go[0] && !flush && !rst;
  assign s0_v     = in_valid && in_ready;
  assign s0_err   = !op_legal(shft_op);

  for (genvar k = 0; k < STG; k++) begin : g_stage
    localparam int unsigned LO  = lvl_lo(k, S, STG);
    localparam int unsigned CNT = lvl_cnt(k, S, STG);
    if (k == 0) begin : g_first
      alu_shft_stage #(.N(N), .S(S), .LO(LO), .CNT(CNT)) u_stage (
        .clk(clk), .rst(rst), .flush(flush), .adv(go[k]),
        .in_v(s0_v), .in_d(in_data), .in_op(shft_op), .in_sh(shamt), .in_err(s0_err),
        .out_v(v[k]), .out_d(d[k]), .out_op(op[k]), .out_sh(sh[k]), .out_err(err[k])
      );
    end else begin : g_next
      alu_shft_stage #(.N(N), .S(S), .LO(LO), .CNT(CNT)) u_stage (
        .clk(clk), .rst(rst), .flush(flush), .adv(go[k]),
        .in_v(v[k-1]), .in_d(d[k-1]), .in_op(op[k-1]), .in_sh(sh[k-1]), .in_err(err[k-1]),
        .out_v(v[k]), .out_d(d[k]), .out_op(op[k]), .out_sh(sh[k]), .out_err(err[k])
      );
    end
  end

  assign out_valid   = v[STG-1];
  assign shft_result = d[STG-1];
  assign out_err     = err[STG-1];

endmodule

// File: tb/tb_alu_shft_pipe.sv
// Directed bench for alu_shft_pipe with a reference queue model checked on every output transfer.
module tb_alu_shft_pipe;
  localparam int unsigned N   = 32;
  localparam int unsigned S   = 5;
  localparam int unsigned STG = 2;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, flush, out_valid, out_ready, out_err;
  logic [N-1:0] in_data, shft_result;
  logic [S-1:0] shamt;
  logic [2:0]   shft_op;

  always #5 clk = ~clk;

  alu_shft_pipe #(.N(N), .S(S), .STG(STG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .shamt(shamt), .shft_op(shft_op), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .shft_result(shft_result), .out_err(out_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: {err, result} straight from the operator definitions.
  function automatic logic [N:0] model(input logic [2:0] op, input logic [N-1:0] x,
                                       input logic [S-1:0] a);
    logic [N-1:0] r;
    logic         e;
    e = 1'b0;
    case (op)
      3'b000:  r = x << a;
      3'b001:  r = x >> a;
      3'b011:  r = $signed(x) >>> a;
      3'b100:  r = (x << a) | (x >> (N - a));
      3'b101:  r = (x >> a) | (x << (N - a));
      default: begin r = x; e = 1'b1; end
    endcase
    return {e, r};
  endfunction

  logic [N:0]   expq [$];
  logic         hold = 1'b0;
  logic [N-1:0] hold_r;
  logic         hold_e;

  always @(posedge clk) begin
    logic [N:0] e;
    if (hold) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_data", 64'(shft_result), 64'(hold_r));
      check("stall_err", 64'(out_err), 64'(hold_e));
    end
    if (out_valid && out_ready && !rst) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %0h want none", shft_result);
      end else begin
        e = expq.pop_front();
        check("model_result", 64'(shft_result), 64'(e[N-1:0]));
        check("model_err", 64'(out_err), 64'(e[N]));
      end
    end
    if (rst || flush) expq.delete();
    else if (in_valid && in_ready) expq.push_back(model(shft_op, in_data, shamt));
    hold   = out_valid && !out_ready && !rst && !flush;
    hold_r = shft_result;
    hold_e = out_err;
  end

  task automatic drive(input logic [2:0] op, input logic [N-1:0] x, input logic [S-1:0] a);
    in_valid = 1'b1;
    shft_op  = op;
    in_data  = x;
    shamt    = a;
  endtask

  task automatic run_one(input string name, input logic [2:0] op, input logic [N-1:0] x,
                         input logic [S-1:0] a, input logic [N-1:0] exp, input logic exp_err);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    drive(op, x, a);
    check({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(STG));
    check({name, "_result"}, 64'(shft_result), 64'(exp));
    check({name, "_err"}, 64'(out_err), 64'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, nv, first, last, idx, acc, guard;
    logic [2:0]   ops   [5];
    logic [2:0]   s_op  [3];
    logic [N-1:0] s_dat [3];
    logic [S-1:0] s_sh  [3];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b011; ops[3] = 3'b100; ops[4] = 3'b101;

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_data = '0; shamt = '0; shft_op = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(shft_result), 64'd0);
    check("rst_err", 64'(out_err), 64'd0);
    rst = 1'b0;
    #1 check("rst_release_in_ready", 64'(in_ready), 64'd1);

    run_one("sra", 3'b011, 32'h8000_00F0, 5'd4, 32'hF800_000F, 1'b0);
    run_one("rol31", 3'b100, 32'h8000_0001, 5'd31, 32'hC000_0000, 1'b0);
    run_one("ror1", 3'b101, 32'h8000_0001, 5'd1, 32'hC000_0000, 1'b0);
    run_one("sll0", 3'b000, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0);
    run_one("sll31", 3'b000, 32'h0000_0003, 5'd31, 32'h8000_0000, 1'b0);
    run_one("srl8", 3'b001, 32'h8765_4321, 5'd8, 32'h0087_6543, 1'b0);
    run_one("sra_pos", 3'b011, 32'h7000_0000, 5'd4, 32'h0700_0000, 1'b0);
    run_one("illegal", 3'b110, 32'h1234_5678, 5'd7, 32'h1234_5678, 1'b1);

    // Back-to-back random legal ops.
    cyc = 0; nv = 0; first = -1; last = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) begin nv++; if (first < 0) first = cyc; last = cyc; end
      cyc++;
      drive(ops[$urandom_range(0, 4)], $urandom(), S'($urandom_range(0, N - 1)));
      check("b2b_in_ready", 64'(in_ready), 64'd1);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin nv++; if (first < 0) first = cyc; last = cyc; end
      cyc++;
    end
    check("b2b_count", 64'(nv), 64'd8);
    check("b2b_span", 64'(last - first), 64'd7);

    // Stall with three pending ops.
    s_op[0] = 3'b000; s_dat[0] = 32'h0000_00FF; s_sh[0] = 5'd4;
    s_op[1] = 3'b101; s_dat[1] = 32'h0000_000F; s_sh[1] = 5'd4;
    s_op[2] = 3'b011; s_dat[2] = 32'hF000_0000; s_sh[2] = 5'd8;
    idx = 0; acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      if (idx < 3) drive(s_op[idx], s_dat[idx], s_sh[idx]);
      #1;
      if (in_valid && in_ready) begin idx++; acc++; end
    end
    check("stall_accepted", 64'(acc), 64'd2);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    guard = 0;
    while (idx < 3 && guard < 20) begin
      @(negedge clk);
      out_ready = 1'b1;
      drive(s_op[idx], s_dat[idx], s_sh[idx]);
      #1;
      if (in_ready) idx++;
      guard++;
    end
    check("stall_third_accepted", 64'(idx), 64'd3);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);

    // Flush with two ops in flight and a pending input.
    drive(3'b000, 32'h0000_0001, 5'd1);
    @(negedge clk);
    drive(3'b001, 32'h0000_0100, 5'd1);
    @(negedge clk);
    drive(3'b100, 32'h0000_0001, 5'd2);
    flush = 1'b1;
    #1 check("flush_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    repeat (5) @(negedge clk);

    // Reset with the pipeline full and stalled.
    out_ready = 1'b0;
    drive(3'b000, 32'h0000_0011, 5'd3);
    @(negedge clk);
    drive(3'b001, 32'hFFFF_0000, 5'd3);
    @(negedge clk);
    in_valid = 1'b0;
    check("prerst_out_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_result", 64'(shft_result), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_err", 64'(out_err), 64'd0);
    rst = 1'b0;
    #1 check("postrst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);

    check("queue_empty", 64'(expq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_shft_pipe.md
ALU_SHFT_PIPE -- requirements
Module: alu_shft_pipe

Interface
REQ-001 SHALL have parameter N, default 32, data width in bits (power of two, 8..64).
REQ-002 SHALL have parameter S, default 5, shift-amount width, equal to log2(N).
REQ-003 SHALL have parameter STG, default 2, number of register stages (1..S).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  operand valid.
REQ-007 SHALL have port in_ready  output  1  block can accept an operand this cycle.
REQ-008 SHALL have port in_data  input  N  data to shift/rotate.
REQ-009 SHALL have port shamt  input  S  shift amount.
REQ-010 SHALL have port shft_op  input  3  op: 000 SLL, 001 SRL, 011 SRA, 100 ROL, 101 ROR; others illegal.
REQ-011 SHALL have port flush  input  1  discard all in-flight operations.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port shft_result  output  N  result.
REQ-015 SHALL have port out_err  output  1  result came from an illegal shft_op; qualified by out_valid.

Function
REQ-016 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-017 Result SHALL match: SLL in_data<<shamt; SRL logical right; SRA sign-filling right; ROL/ROR rotate modulo N; shamt=0 returns in_data unchanged for every legal op.
REQ-018 Illegal shft_op SHALL yield shft_result = in_data with out_err=1 at normal latency.
REQ-019 Barrel levels 2^0..2^(S-1) SHALL be processed LSB first, split over STG stages; the first (S mod STG) stages take floor(S/STG)+1 levels, the rest floor(S/STG).
REQ-020 Latency SHALL be exactly STG cycles from input transfer to out_valid when out_ready stays high.
REQ-021 Throughput SHALL be one operation per cycle with out_ready held high.
REQ-022 Each stage SHALL hold a valid bit and SHALL advance when empty or when its successor advances in the same cycle (bubble collapsing); in_ready = stage-0 can advance && !flush.
REQ-023 With out_ready low and all stages full, in_ready SHALL be 0 and all stage contents and outputs SHALL hold stable.
REQ-024 shft_result and out_err SHALL be held stable while out_valid && !out_ready.
REQ-025 flush SHALL clear every valid bit on the next edge; no input is accepted in a flush cycle; an output handshake in the same cycle as flush still completes.
REQ-026 op, shamt-remainder and data SHALL travel with each stage's valid bit; no cross-operation mixing under stalls.

Reset
REQ-027 While rst is high on an edge, all valid bits, shft_result and out_err SHALL be cleared to 0.
REQ-028 in_ready SHALL be 0 while rst is high and 1 on the first cycle after rst deasserts.
REQ-029 rst asserted mid-operation SHALL discard all in-flight operations without producing out_valid.

Structure
REQ-030 Op encodings (SLL/SRL/SRA/ROL/ROR) SHALL live in shared package alu_shft_pkg, reused by the ALU decoder.
REQ-031 One sub-module alu_shft_stage SHALL implement a parametrised group of barrel levels plus its valid/data register, instantiated STG times via generate.

Verification
REQ-032 N=32, STG=2: SRA in_data=0x8000_00F0, shamt=4 -> after 2 cycles shft_result=0xF800_000F, out_err=0.
REQ-033 ROL in_data=0x8000_0001, shamt=31 -> 0xC000_0000; ROR same data, shamt=1 -> 0xC000_0000; SLL shamt=0 -> unchanged.
REQ-034 Back-to-back 8 random ops with out_ready=1 -> 8 consecutive out_valid cycles, results equal to reference model, in order.
REQ-035 out_ready=0 for 5 cycles while 3 ops issued -> in_ready drops after 2 accepted, shft_result stable; release -> both drain in order, third accepted.
REQ-036 flush with 2 ops in flight and in_valid high -> no out_valid next cycle, input not accepted; shft_op=110 -> shft_result=in_data, out_err=1.
REQ-037 rst asserted with pipeline full -> next cycle out_valid=0, shft_result=0, in_ready=0; first cycle after release in_ready=1.
